bank_burst_master: RTL and testbench
====================================

# bank_burst_master

Initiator side of the bank-group data interface: accepts one read or write request at a time, selects a bank, and sequences a BL-beat burst by stepping the column address and driving or capturing one DEVICE_WIDTH beat per cycle. Sits between the DDR command FSM and the bank group. Presents a valid/ready request port upstream and a response port carrying the assembled read burst.

## Interface
- BAWIDTH, 2, bank-select width; BANKSPERGROUP = 2**BAWIDTH
- ADDRWIDTH, 17, row address width
- COLWIDTH, 10, column address width
- DEVICE_WIDTH, 4, data bits per beat
- BL, 8, burst length in beats (power of two, ≥4, ≤2**COLWIDTH)
- RDLAT, 1, cycles from column presented to valid bank dqout (≥0)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_bank  in  BAWIDTH  target bank
- req_row  in  ADDRWIDTH  row
- req_col  in  COLWIDTH  starting column
- req_wdata  in  BL*DEVICE_WIDTH  write burst; beat k = bits [k*DEVICE_WIDTH +: DEVICE_WIDTH]
- rsp_valid  out  1  read burst complete (one-cycle pulse)
- rsp_rdata  out  BL*DEVICE_WIDTH  assembled read burst, same beat packing
- rd_o_wr  out  BANKSPERGROUP  per bank: 1 = write, 0 = read
- dqin  out  BANKSPERGROUP×DEVICE_WIDTH  per-bank write data
- dqout  in  BANKSPERGROUP×DEVICE_WIDTH  per-bank read data
- row  out  BANKSPERGROUP×ADDRWIDTH  per-bank row
- column  out  BANKSPERGROUP×COLWIDTH  per-bank column

## Operation
- States: IDLE, BURST, DRAIN, RESP.
- IDLE: req_ready=1. On handshake latch write/bank/row/col/wdata, beat counter=0, go BURST.
- BURST: each cycle present beat k to latched bank: column = {col[COLWIDTH-1:log2 BL], (col[log2 BL-1:0]+k) mod BL} (wrap within BL-aligned block); row = latched row; on write rd_o_wr[bank]=1, dqin[bank]=wdata beat k. After beat BL-1: write → IDLE; read → DRAIN if RDLAT>0, else RESP.
- Read capture: dqout[bank] sampled RDLAT cycles after its column was presented, stored at beat index k (burst order, not column order). RDLAT=0 samples in the same cycle.
- DRAIN: wait until last beat captured, then RESP.
- RESP: rsp_valid=1 for one cycle, rsp_rdata stable until next read completes; → IDLE.
- Non-selected banks and all banks outside BURST: rd_o_wr=0, dqin=0, row and column hold last driven value (0 after reset).
- Arithmetic: beat counter log2(BL) bits; column offset add truncates to log2(BL) bits; no carry into upper column bits.
- No back-pressure on response; upstream must consume rsp_valid pulse.

## Timing
- Reset (asynchronous, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rd_o_wr=0, dqin=0, row=0, column=0; burst in progress is abandoned, no rsp_valid emitted.
- Write: handshake cycle T, beats on T+1..T+BL, req_ready=1 again at T+BL+1.
- Read: beats presented T+1..T+BL, last capture T+BL+RDLAT, rsp_valid at T+BL+RDLAT+1, req_ready at T+BL+RDLAT+2.
- req_ready=0 in BURST, DRAIN, RESP; requests are never accepted back-to-back without one IDLE cycle.
- Request inputs are ignored outside the handshake cycle.

## Configuration
- BANK_BURST_CHOP_EN: adds input req_bc4 (1 bit). When set on a request, burst is BL/2 beats (wrap within BL/2-aligned block), remaining rsp_rdata beats are zero, all latencies use BL/2. Without the macro, the port does not exist and every burst is BL beats.

## Test plan
- Reset mid-read (assert rst_n=0 at beat 3) -> all outputs at reset values, no rsp_valid, next request served normally.
- Write bank 2, row 0x1A5, col 0x008, wdata 0x76543210 (BL=8, DW=4) -> rd_o_wr=4'b0100 for 8 cycles, columns 0x008..0x00F, dqin[2]=0,1,..,7.
- Read back same address, RDLAT=1 -> rsp_valid exactly at T+10, rsp_rdata=0x76543210.
- Wrap: read col 0x00D -> columns 0x00D,0x00E,0x00F,0x008..0x00C; rsp beat 0 = data at column 0x00D.
- req_valid held high continuously for two writes -> second accepted only at T+9, no bank overlap.
- BANK_BURST_CHOP_EN, read with req_bc4=1 at col 0x006 -> columns 0x006,0x007,0x004,0x005, rsp_valid at T+6, upper 16 bits of rsp_rdata zero.

Source files
------------

// File: rtl/bank_burst_if.sv
// bank_burst_if: upstream request/response bundle for bank_burst_master.
// With BANK_BURST_CHOP_EN defined the bundle also carries req_bc4 (burst chop).
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// rsp_valid is a one-cycle pulse with no ready; the consumer must take it.
interface bank_burst_if #(
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 17,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8
) ();
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [BAWIDTH-1:0]           req_bank;
  logic [ADDRWIDTH-1:0]         req_row;
  logic [COLWIDTH-1:0]          req_col;
  logic [BL*DEVICE_WIDTH-1:0]   req_wdata;
`ifdef BANK_BURST_CHOP_EN
  logic                         req_bc4;
`endif
  logic                         rsp_valid;
  logic [BL*DEVICE_WIDTH-1:0]   rsp_rdata;

  // Upstream side (DDR command FSM).
  modport master (
`ifdef BANK_BURST_CHOP_EN
    output req_bc4,
`endif
    output req_valid, req_write, req_bank, req_row, req_col, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Burst master side.
  modport slave (
`ifdef BANK_BURST_CHOP_EN
    input  req_bc4,
`endif
    input  req_valid, req_write, req_bank, req_row, req_col, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bank_burst_master.sv
// bank_burst_master: accepts one read/write request at a time and sequences a
// BL-beat burst to one bank, wrapping the column inside its BL-aligned block.
// Read beats are captured RDLAT cycles after their column and returned as one
// packed burst with a single rsp_valid pulse.
// Optional feature macro: BANK_BURST_CHOP_EN (req_bc4 selects a BL/2 burst).
module bank_burst_master #(
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 17,
  parameter int COLWIDTH     = 10,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int RDLAT        = 1,
  localparam int BANKSPERGROUP = 2**BAWIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  bank_burst_if.slave                                    bus,
  output logic [BANKSPERGROUP-1:0]                       rd_o_wr,
  output logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]     dqin,
  input  logic [BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0]     dqout,
  output logic [BANKSPERGROUP-1:0][ADDRWIDTH-1:0]        row,
  output logic [BANKSPERGROUP-1:0][COLWIDTH-1:0]         column,
  output logic [1:0]                                     dbg_state
);
  localparam int DW  = DEVICE_WIDTH;
  localparam int LBL = $clog2(BL);
  localparam int PD  = (RDLAT > 0) ? RDLAT : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic               wr_q;
  logic               bc4_q;
  logic [BAWIDTH-1:0] bank_q;
  logic [COLWIDTH-1:0] col_q;
  logic [BL*DW-1:0]   wdata_q;
  logic [BL*DW-1:0]   cap_buf;
  logic [BL*DW-1:0]   cap_next;
  logic [BL*DW-1:0]   rsp_rdata_q;
  logic [LBL-1:0]     cnt;
  logic [LBL-1:0]     nk;
  logic [LBL-1:0]     last_idx;
  logic [LBL-1:0]     cap_i;
  logic               req_bc4;
  logic               hs;
  logic               beat_last;
  logic               cap_v;
  logic               cap_last;
  logic               req_ready;
  logic               rsp_valid;
  logic               pv   [PD];
  logic [LBL-1:0]     pidx [PD];

`ifdef BANK_BURST_CHOP_EN
  assign req_bc4 = bus.req_bc4;
`else
  assign req_bc4 = 1'b0;
`endif

  // Column of beat k: offset added modulo the burst length, upper bits untouched.
  // A chopped burst keeps bit LBL-1 of the start column so it wraps in BL/2.
  function automatic logic [COLWIDTH-1:0] col_of(input logic [COLWIDTH-1:0] base,
                                                 input logic [LBL-1:0] k,
                                                 input logic half);
    logic [COLWIDTH-1:0] c;
    logic [LBL-1:0]      low;
    low = base[LBL-1:0] + k;
    if (half) low[LBL-1] = base[LBL-1];
    c = base;
    c[LBL-1:0] = low;
    return c;
  endfunction

  assign hs            = (state == IDLE) && bus.req_valid;
  assign last_idx      = bc4_q ? LBL'(BL/2 - 1) : LBL'(BL - 1);
  assign beat_last     = (cnt == last_idx);
  assign nk            = cnt + LBL'(1);
  assign dbg_state     = state;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Read capture point: same cycle for RDLAT=0, else the end of the delay line.
  always_comb begin
    cap_v = 1'b0;
    cap_i = '0;
    if (RDLAT == 0) begin
      cap_v = (state == BURST) && !wr_q;
      cap_i = cnt;
    end else begin
      cap_v = pv[PD-1];
      cap_i = pidx[PD-1];
    end
    cap_last = cap_v && (cap_i == last_idx);
    cap_next = cap_buf;
    if (cap_v) cap_next[cap_i*DW +: DW] = dqout[bank_q];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_nxt = BURST;
      end
      BURST: begin
        if (beat_last) begin
          if (wr_q)           state_nxt = IDLE;
          else if (RDLAT > 0) state_nxt = DRAIN;
          else                state_nxt = RESP;
        end
      end
      DRAIN: begin
        if (cap_last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and beat counter; inputs are only looked at on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      bc4_q   <= 1'b0;
      bank_q  <= '0;
      col_q   <= '0;
      wdata_q <= '0;
      cnt     <= '0;
    end else if (hs) begin
      wr_q    <= bus.req_write;
      bc4_q   <= req_bc4;
      bank_q  <= bus.req_bank;
      col_q   <= bus.req_col;
      wdata_q <= bus.req_wdata;
      cnt     <= '0;
    end else if (state == BURST) begin
      cnt     <= nk;
    end
  end

  // Delay line tagging each presented read beat with its burst index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PD; i++) begin
        pv[i]   <= 1'b0;
        pidx[i] <= '0;
      end
    end else begin
      pv[0]   <= (state == BURST) && !wr_q;
      pidx[0] <= cnt;
      for (int i = 1; i < PD; i++) begin
        pv[i]   <= pv[i-1];
        pidx[i] <= pidx[i-1];
      end
    end
  end

  // Capture buffer (cleared per request so chopped bursts leave zero beats)
  // and the response register, which only changes when a read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_buf     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (hs)         cap_buf <= '0;
      else if (cap_v) cap_buf <= cap_next;
      if ((state_nxt == RESP) && (state != RESP)) rsp_rdata_q <= cap_next;
    end
  end

  // Bank-side drive, registered so beat k is on the pins while cnt == k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_o_wr <= '0;
      dqin    <= '0;
      row     <= '0;
      column  <= '0;
    end else begin
      rd_o_wr <= '0;
      dqin    <= '0;
      if (hs) begin
        row[bus.req_bank]     <= bus.req_row;
        column[bus.req_bank]  <= bus.req_col;
        rd_o_wr[bus.req_bank] <= bus.req_write;
        if (bus.req_write) dqin[bus.req_bank] <= bus.req_wdata[DW-1:0];
      end else if ((state == BURST) && !beat_last) begin
        column[bank_q]  <= col_of(col_q, nk, bc4_q);
        rd_o_wr[bank_q] <= wr_q;
        if (wr_q) dqin[bank_q] <= wdata_q[nk*DW +: DW];
      end
    end
  end
endmodule

// File: tb/tb_bank_burst_master.sv
// tb_bank_burst_master: directed and randomized bursts against a reference
// model that keeps its own copy of bank contents and derives expected columns
// and read bursts with plain modulo arithmetic.
module tb_bank_burst_master;
  localparam int BAWIDTH   = 2;
  localparam int ADDRWIDTH = 17;
  localparam int COLWIDTH  = 10;
  localparam int DW        = 4;
  localparam int BL        = 8;
  localparam int RDLAT     = 1;
  localparam int NB        = 1 << BAWIDTH;
  localparam int NCOL      = 1 << COLWIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NB-1:0]                 rd_o_wr;
  logic [NB-1:0][DW-1:0]         dqin;
  logic [NB-1:0][DW-1:0]         dqout;
  logic [NB-1:0][ADDRWIDTH-1:0]  row;
  logic [NB-1:0][COLWIDTH-1:0]   column;
  logic [1:0]                    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BL*DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem  [NB][NCOL];
  logic [DW-1:0] bank_mem [NB][NCOL];
  bit mem_ready = 1'b0;

  bank_burst_if #(.BAWIDTH(BAWIDTH), .ADDRWIDTH(ADDRWIDTH), .COLWIDTH(COLWIDTH),
                  .DEVICE_WIDTH(DW), .BL(BL)) bus ();

  bank_burst_master #(.BAWIDTH(BAWIDTH), .ADDRWIDTH(ADDRWIDTH), .COLWIDTH(COLWIDTH),
                      .DEVICE_WIDTH(DW), .BL(BL), .RDLAT(RDLAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rd_o_wr   (rd_o_wr),
    .dqin      (dqin),
    .dqout     (dqout),
    .row       (row),
    .column    (column),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int b, int c);
    return DW'((b * 13 + c * 7 + (c >> 4)) & 'hF);
  endfunction

  // Bank group model: one-cycle read latency, writes on rd_o_wr.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dqout <= '0;
      if (!mem_ready) begin
        for (int b = 0; b < NB; b++)
          for (int c = 0; c < NCOL; c++) bank_mem[b][c] <= init_val(b, c);
        mem_ready <= 1'b1;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (rd_o_wr[b]) bank_mem[b][column[b]] <= dqin[b];
        dqout[b] <= bank_mem[b][column[b]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Column for beat k: start of the aligned block plus wrapped offset.
  function automatic int exp_col(int col, int k, int blen);
    return (col / blen) * blen + (col + k) % blen;
  endfunction

  // One request from handshake to return to IDLE; called and returns at a negedge.
  task automatic run_req(input bit wr, input int bank, input int rrow, input int col,
                         input logic [BL*DW-1:0] wdata, input bit bc4, input bit keep_valid);
    int blen;
    int waited;
    int c;
    logic [BL*DW-1:0] exp_rd;
    logic [BL*DW-1:0] got_exp;
    logic [63:0] exp_dq;
    blen = bc4 ? BL / 2 : BL;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_bank  = BAWIDTH'(bank);
    bus.req_row   = ADDRWIDTH'(rrow);
    bus.req_col   = COLWIDTH'(col);
    bus.req_wdata = wdata;
`ifdef BANK_BURST_CHOP_EN
    bus.req_bc4   = bc4;
`endif
    waited = 0;
    while (!bus.req_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    exp_rd = '0;
    for (int k = 0; k < blen; k++) begin
      c = exp_col(col, k, blen);
      if (wr) ref_mem[bank][c] = wdata[k*DW +: DW];
      else    exp_rd[k*DW +: DW] = ref_mem[bank][c];
    end
    if (!wr) exp_q.push_back(exp_rd);
    @(negedge clk);
    if (!keep_valid) begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'($urandom);
      bus.req_bank  = BAWIDTH'($urandom);
      bus.req_row   = ADDRWIDTH'($urandom);
      bus.req_col   = COLWIDTH'($urandom);
      bus.req_wdata = (BL*DW)'($urandom);
    end
    for (int k = 0; k < blen; k++) begin
      exp_dq = '0;
      if (wr) exp_dq[bank*DW +: DW] = wdata[k*DW +: DW];
      check("rd_o_wr", 64'(rd_o_wr), wr ? (64'd1 << bank) : 64'd0);
      check("column", 64'(column[bank]), 64'(exp_col(col, k, blen)));
      check("row", 64'(row[bank]), 64'(rrow));
      check("dqin", 64'(dqin), exp_dq);
      check("req_ready_busy", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    if (wr) begin
      check("req_ready_after_wr", 64'(bus.req_ready), 64'd1);
      check("rd_o_wr_after_wr", 64'(rd_o_wr), 64'd0);
    end else begin
      for (int d = 0; d < RDLAT; d++) begin
        check("rsp_valid_early", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
      end
      check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
      got_exp = exp_q.pop_front();
      check("rsp_rdata", 64'(bus.rsp_rdata), 64'(got_exp));
      @(negedge clk);
      check("rsp_valid_pulse", 64'(bus.rsp_valid), 64'd0);
      check("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(got_exp));
      check("req_ready_after_rd", 64'(bus.req_ready), 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    check({tag, "_rd_o_wr"}, 64'(rd_o_wr), 64'd0);
    check({tag, "_dqin"}, 64'(dqin), 64'd0);
    check({tag, "_row"}, 64'(row), 64'd0);
    check({tag, "_column"}, 64'(column), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus and final report.
  initial begin
    int pulses;
    bit wr;
    bit bc4;
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < NCOL; c++) ref_mem[b][c] = init_val(b, c);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_bank  = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.req_wdata = '0;
`ifdef BANK_BURST_CHOP_EN
    bus.req_bc4   = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write, read back, wrapped read.
    run_req(1'b1, 2, 'h1A5, 'h008, 32'h7654_3210, 1'b0, 1'b0);
    run_req(1'b0, 2, 'h1A5, 'h008, '0, 1'b0, 1'b0);
    run_req(1'b0, 2, 'h1A5, 'h00D, '0, 1'b0, 1'b0);

    // Two writes with req_valid held high throughout.
    run_req(1'b1, 1, 'h3, 'h020, 32'h9ABC_DEF0, 1'b0, 1'b1);
    run_req(1'b1, 3, 'h4, 'h3F5, 32'h1357_9BDF, 1'b0, 1'b0);
    run_req(1'b0, 3, 'h4, 'h3F0, '0, 1'b0, 1'b0);

`ifdef BANK_BURST_CHOP_EN
    run_req(1'b0, 1, 'h10, 'h006, '0, 1'b1, 1'b0);
`endif

    // Reset asserted while beat 3 of a read is on the pins.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_bank  = 2'd3;
    bus.req_row   = 17'h5;
    bus.req_col   = 10'h100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    check("no_rsp_after_reset", 64'(pulses), 64'd0);
    run_req(1'b0, 2, 'h1A5, 'h008, '0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      wr  = 1'($urandom_range(0, 1));
      bc4 = 1'b0;
`ifdef BANK_BURST_CHOP_EN
      bc4 = 1'($urandom_range(0, 1));
`endif
      run_req(wr, $urandom_range(0, NB - 1), $urandom_range(0, (1 << ADDRWIDTH) - 1),
              $urandom_range(0, NCOL - 1), (BL*DW)'($urandom), bc4, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
